// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the wait-state data-memory responder.
// FSM encoding and default geometry used by dmem_responder and dmem_array.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEFAULT_BIT_NUMBER = 32;
    localparam int DEFAULT_BASE_ADDR  = 1024;
    localparam int DEFAULT_DEPTH      = 64;

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory bus. With DMEM_RANGE_CHECK_EN defined the bus also
// carries err, flagging an out-of-range or misaligned access in its ready cycle.
//
// Handshake: the master holds mem_r_en/mem_w_en (plus addr/wdata) high until it
// sees ready; freeze = request & ~ready, and ready is a single-cycle pulse.
interface dmem_responder_if #(
    parameter int BIT_NUMBER = 32
);
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [BIT_NUMBER-1:0] addr;
    logic [BIT_NUMBER-1:0] wdata;
    logic [BIT_NUMBER-1:0] rdata;
    logic                  ready;
    logic                  freeze;
`ifdef DMEM_RANGE_CHECK_EN
    logic                  err;

    modport master (output mem_r_en, mem_w_en, addr, wdata,
                    input  rdata, ready, freeze, err);
    modport slave  (input  mem_r_en, mem_w_en, addr, wdata,
                    output rdata, ready, freeze, err);
`else
    modport master (output mem_r_en, mem_w_en, addr, wdata,
                    input  rdata, ready, freeze);
    modport slave  (input  mem_r_en, mem_w_en, addr, wdata,
                    output rdata, ready, freeze);
`endif
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: word storage with a write-enable port and a registered read port.
// Synchronous reset clears every word and the read register.
module dmem_array #(
    parameter int BIT_NUMBER = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  rd_zero_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [BIT_NUMBER-1:0] wdata_i,
    output logic [BIT_NUMBER-1:0] rdata_o
);

    logic [BIT_NUMBER-1:0] mem_q [DEPTH];
    logic [BIT_NUMBER-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            // rd_zero_i forces a zero load for rejected reads
            if (re_i) begin
                rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one MEM-stage access after WAIT_CYCLES wait
// states with a one-cycle ready pulse. Optional DMEM_RANGE_CHECK_EN adds err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int BIT_NUMBER  = DEFAULT_BIT_NUMBER,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus,
    output state_e            dbg_state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]      WAIT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [BIT_NUMBER-1:0] BASE_V    = BIT_NUMBER'(BASE_ADDR);
    localparam logic [BIT_NUMBER-1:0] DEPTH_V   = BIT_NUMBER'(DEPTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BIT_NUMBER-1:0] wdata_q, wdata_d;

    logic                  req;
    logic [BIT_NUMBER-1:0] offset, word_full, word_mod;
    logic [IDX_W-1:0]      live_idx;
    logic                  arr_we, arr_re, arr_zero;
    logic [IDX_W-1:0]      arr_idx;
    logic [BIT_NUMBER-1:0] arr_wdata;
    logic                  ready;

`ifdef DMEM_RANGE_CHECK_EN
    logic bad_q, bad_d, live_bad, arr_bad;
`endif

    assign req = bus.mem_r_en | bus.mem_w_en;

    always_comb begin
        offset    = bus.addr - BASE_V;
        word_full = offset >> 2;
        word_mod  = word_full % DEPTH_V;
        live_idx  = IDX_W'(word_mod);
    end

`ifdef DMEM_RANGE_CHECK_EN
    // range is judged on the unwrapped word index
    assign live_bad = (bus.addr < BASE_V) || (word_full >= DEPTH_V) ||
                      (bus.addr[1:0] != 2'b00);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_idx   = idx_q;
        arr_wdata = wdata_q;
`ifdef DMEM_RANGE_CHECK_EN
        bad_d     = bad_q;
        arr_bad   = bad_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = bus.mem_w_en;
                    idx_d   = live_idx;
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
`ifdef DMEM_RANGE_CHECK_EN
                    bad_d   = live_bad;
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        // zero wait states: this edge enters RESP, so commit from the live bus
                        state_d   = ST_RESP;
                        arr_we    = bus.mem_w_en;
                        arr_re    = ~bus.mem_w_en;
                        arr_idx   = live_idx;
                        arr_wdata = bus.wdata;
`ifdef DMEM_RANGE_CHECK_EN
                        arr_bad   = live_bad;
`endif
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == WAIT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    arr_we  = wr_q;
                    arr_re  = ~wr_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
`ifdef DMEM_RANGE_CHECK_EN
            bad_q   <= bad_d;
`endif
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic arr_we_ok;
    assign arr_we_ok = arr_we & ~arr_bad;
    assign arr_zero  = arr_bad;
`else
    logic arr_we_ok;
    assign arr_we_ok = arr_we;
    assign arr_zero  = 1'b0;
`endif

    dmem_array #(
        .BIT_NUMBER (BIT_NUMBER),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .we_i      (arr_we_ok),
        .re_i      (arr_re),
        .rd_zero_i (arr_zero),
        .idx_i     (arr_idx),
        .wdata_i   (arr_wdata),
        .rdata_o   (bus.rdata)
    );

    assign ready       = (state_q == ST_RESP);
    assign bus.ready   = ready;
    assign bus.freeze  = req & ~ready;
    assign dbg_state_o = state_q;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.err     = ready & bad_q;
`endif

endmodule
